// File: rtl/grey_pkg.sv
// Gray-code helpers and step-command encoding shared by the counter files.
// Latency: pure combinational functions, no state.
// Backpressure: none; callers consume results in the same cycle.
package grey_pkg;

  // Widest counter supported; helpers work at this width and callers truncate.
  localparam int unsigned MAX_W = 32;

  // One decoded command per clock edge, already resolved by priority.
  typedef enum logic [2:0] {
    HOLD = 3'd0,
    UP   = 3'd1,
    DOWN = 3'd2,
    CLR  = 3'd3,
    LOAD = 3'd4
  } step_cmd_e;

  // Reflected binary to Gray: each Gray bit is the XOR of adjacent binary bits.
  function automatic logic [MAX_W-1:0] f_bin2gray(input logic [MAX_W-1:0] x);
    return x ^ (x >> 1);
  endfunction

  // Gray to binary: running XOR from the MSB down. Zero-extended inputs are
  // safe because leading zeros leave the running XOR untouched.
  function automatic logic [MAX_W-1:0] f_gray2bin(input logic [MAX_W-1:0] g);
    logic [MAX_W-1:0] b;
    b[MAX_W-1] = g[MAX_W-1];
    for (int i = MAX_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // Resolve the raw control pins into one command: clr > load > single step.
  // inc and dec together cancel out and hold the count.
  function automatic step_cmd_e f_decode_cmd(input logic clr,
                                             input logic load,
                                             input logic inc,
                                             input logic dec);
    step_cmd_e cmd;
    cmd = HOLD;
    if (clr) begin
      cmd = CLR;
    end else if (load) begin
      cmd = LOAD;
    end else if (inc && !dec) begin
      cmd = UP;
    end else if (dec && !inc) begin
      cmd = DOWN;
    end
    return cmd;
  endfunction

endpackage

// File: rtl/grey_rst_sync.sv
// Reset synchroniser: asserts asynchronously, releases on the clock.
// Latency: release appears on the 2nd rising clk edge after rst goes high.
// Backpressure: none; free-running two-flop chain.
module grey_rst_sync (
  input  logic clk,
  input  logic rst,
  output logic rst_sync_n
);

  logic meta_q;
  logic sync_q;

  // Two-flop chain: rst low clears both at once, a high rst walks a 1 through.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= 1'b1;
      sync_q <= meta_q;
    end
  end

  assign rst_sync_n = sync_q;

endmodule

// File: rtl/grey_code_counter.sv
// Parametrised Gray counter with up/down, load, clear and wrap/saturate modes.
// Latency: 1 cycle from an accepted command to grey, grey_next, bin and flags.
// Backpressure: none; a command is acted on every clock edge out of reset.
module grey_code_counter
  import grey_pkg::*;
#(
  parameter int unsigned      WIDTH   = 6,
  parameter bit               WRAP    = 1'b1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_grey,
  input  logic             inc,
  input  logic             dec,
  output logic [WIDTH-1:0] grey,
  output logic [WIDTH-1:0] grey_next,
  output logic [WIDTH-1:0] bin,
  output logic             at_max,
  output logic             at_min,
  output logic             wrapped
);

  localparam logic [WIDTH-1:0] MAX_CNT = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

  // Width-local views of the package helpers.
  function automatic logic [WIDTH-1:0] to_gray(input logic [WIDTH-1:0] x);
    return WIDTH'(f_bin2gray(MAX_W'(x)));
  endfunction

  function automatic logic [WIDTH-1:0] from_gray(input logic [WIDTH-1:0] g);
    return WIDTH'(f_gray2bin(MAX_W'(g)));
  endfunction

  // Count one step up under the wrap rule; saturating counters stick at max.
  function automatic logic [WIDTH-1:0] succ(input logic [WIDTH-1:0] x);
    logic [WIDTH-1:0] r;
    r = x + ONE;
    if (!WRAP && (x == MAX_CNT)) begin
      r = x;
    end
    return r;
  endfunction

  localparam logic [WIDTH-1:0] RST_GREY = to_gray(RST_VAL);
  localparam logic [WIDTH-1:0] RST_NEXT = to_gray(succ(RST_VAL));
  localparam logic             RST_MAX  = (RST_VAL == MAX_CNT);
  localparam logic             RST_MIN  = (RST_VAL == '0);

  logic             w_rst_n;
  step_cmd_e        cmd;
  logic [WIDTH-1:0] bin_q;
  logic [WIDTH-1:0] bin_nxt;
  logic             wrap_nxt;
  logic [WIDTH-1:0] grey_q;
  logic [WIDTH-1:0] grey_next_q;
  logic             at_max_q;
  logic             at_min_q;
  logic             wrapped_q;

  // The counter only runs once the released reset has been retimed to clk.
  grey_rst_sync u_rst_sync (
    .clk        (clk),
    .rst        (rst),
    .rst_sync_n (w_rst_n)
  );

  // Next binary count and wrap event for this edge.
  always_comb begin
    cmd      = f_decode_cmd(clr, load, inc, dec);
    bin_nxt  = bin_q;
    wrap_nxt = 1'b0;
    unique case (cmd)
      CLR: begin
        bin_nxt = RST_VAL;
      end
      LOAD: begin
        bin_nxt = from_gray(load_grey);
      end
      UP: begin
        if (bin_q == MAX_CNT) begin
          if (WRAP) begin
            bin_nxt  = '0;
            wrap_nxt = 1'b1;
          end
        end else begin
          bin_nxt = bin_q + ONE;
        end
      end
      DOWN: begin
        if (bin_q == '0) begin
          if (WRAP) begin
            bin_nxt  = MAX_CNT;
            wrap_nxt = 1'b1;
          end
        end else begin
          bin_nxt = bin_q - ONE;
        end
      end
      default: begin
        bin_nxt = bin_q;
      end
    endcase
  end

  // Every output is registered from the same next count so they move together
  // and nothing combinational reaches the cross-domain Gray bus.
  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      bin_q       <= RST_VAL;
      grey_q      <= RST_GREY;
      grey_next_q <= RST_NEXT;
      at_max_q    <= RST_MAX;
      at_min_q    <= RST_MIN;
      wrapped_q   <= 1'b0;
    end else begin
      bin_q       <= bin_nxt;
      grey_q      <= to_gray(bin_nxt);
      grey_next_q <= to_gray(succ(bin_nxt));
      at_max_q    <= (bin_nxt == MAX_CNT);
      at_min_q    <= (bin_nxt == '0);
      wrapped_q   <= wrap_nxt;
    end
  end

  assign grey      = grey_q;
  assign grey_next = grey_next_q;
  assign bin       = bin_q;
  assign at_max    = at_max_q;
  assign at_min    = at_min_q;
  assign wrapped   = wrapped_q;

endmodule

// File: tb/tb_grey_code_counter.sv
// Directed bench: four counter builds driven from shared controls and checked
// every cycle against a behavioural count model, plus literal spot values.
module tb_grey_code_counter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        clr = 1'b0;
  logic        load = 1'b0;
  logic        inc = 1'b0;
  logic        dec = 1'b0;
  logic [31:0] lg = '0;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  // Instance outputs: a = W6 wrap, b = W6 saturate, c = W2 wrap, d = W32 wrap
  logic [5:0]  a_grey, a_gn, a_bin;
  logic [5:0]  b_grey, b_gn, b_bin;
  logic [1:0]  c_grey, c_gn, c_bin;
  logic [31:0] d_grey, d_gn, d_bin;
  logic a_max, a_min, a_wr, b_max, b_min, b_wr;
  logic c_max, c_min, c_wr, d_max, d_min, d_wr;

  grey_code_counter dut (
    .clk(clk), .rst(rst), .clr(clr), .load(load), .load_grey(lg[5:0]),
    .inc(inc), .dec(dec), .grey(a_grey), .grey_next(a_gn), .bin(a_bin),
    .at_max(a_max), .at_min(a_min), .wrapped(a_wr));

  grey_code_counter #(.WIDTH(6), .WRAP(1'b0)) dut_sat (
    .clk(clk), .rst(rst), .clr(clr), .load(load), .load_grey(lg[5:0]),
    .inc(inc), .dec(dec), .grey(b_grey), .grey_next(b_gn), .bin(b_bin),
    .at_max(b_max), .at_min(b_min), .wrapped(b_wr));

  grey_code_counter #(.WIDTH(2), .WRAP(1'b1)) dut_w2 (
    .clk(clk), .rst(rst), .clr(clr), .load(load), .load_grey(lg[1:0]),
    .inc(inc), .dec(dec), .grey(c_grey), .grey_next(c_gn), .bin(c_bin),
    .at_max(c_max), .at_min(c_min), .wrapped(c_wr));

  grey_code_counter #(.WIDTH(32), .WRAP(1'b1)) dut_w32 (
    .clk(clk), .rst(rst), .clr(clr), .load(load), .load_grey(lg),
    .inc(inc), .dec(dec), .grey(d_grey), .grey_next(d_gn), .bin(d_bin),
    .at_max(d_max), .at_min(d_min), .wrapped(d_wr));

  logic [63:0] o_grey[4];
  logic [63:0] o_gn[4];
  logic [63:0] o_bin[4];
  logic        o_max[4];
  logic        o_min[4];
  logic        o_wr[4];

  assign o_grey[0] = 64'(a_grey); assign o_gn[0] = 64'(a_gn); assign o_bin[0] = 64'(a_bin);
  assign o_grey[1] = 64'(b_grey); assign o_gn[1] = 64'(b_gn); assign o_bin[1] = 64'(b_bin);
  assign o_grey[2] = 64'(c_grey); assign o_gn[2] = 64'(c_gn); assign o_bin[2] = 64'(c_bin);
  assign o_grey[3] = 64'(d_grey); assign o_gn[3] = 64'(d_gn); assign o_bin[3] = 64'(d_bin);
  assign o_max[0] = a_max; assign o_min[0] = a_min; assign o_wr[0] = a_wr;
  assign o_max[1] = b_max; assign o_min[1] = b_min; assign o_wr[1] = b_wr;
  assign o_max[2] = c_max; assign o_min[2] = c_min; assign o_wr[2] = c_wr;
  assign o_max[3] = d_max; assign o_min[3] = d_min; assign o_wr[3] = d_wr;

  // ---------------- behavioural model ----------------
  int unsigned wv[4] = '{6, 6, 2, 32};
  bit          wp[4] = '{1'b1, 1'b0, 1'b1, 1'b1};
  logic [63:0] mc[4] = '{64'd0, 64'd0, 64'd0, 64'd0};
  bit          mw[4] = '{1'b0, 1'b0, 1'b0, 1'b0};
  int          edges = 0;
  bit          single = 1'b0;

  function automatic logic [63:0] mx(input int unsigned w);
    return (64'd1 << w) - 64'd1;
  endfunction

  function automatic logic [63:0] gr(input logic [63:0] x);
    return x ^ (x >> 1);
  endfunction

  function automatic logic [63:0] g2b(input logic [63:0] gv, input int unsigned w);
    logic [63:0] b;
    bit acc;
    b = '0;
    acc = 1'b0;
    for (int i = int'(w) - 1; i >= 0; i--) begin
      acc ^= gv[i];
      b[i] = acc;
    end
    return b;
  endfunction

  // Count state per build; commands honoured from the 3rd edge after release.
  always @(posedge clk or negedge rst) begin
    single = 1'b0;
    if (!rst) begin
      edges = 0;
      for (int i = 0; i < 4; i++) begin
        mc[i] = '0;
        mw[i] = 1'b0;
      end
    end else begin
      if (edges < 3) edges++;
      for (int i = 0; i < 4; i++) begin
        logic [63:0] m, c, n;
        bit w;
        m = mx(wv[i]);
        c = mc[i];
        n = c;
        w = 1'b0;
        if (edges >= 3) begin
          if (clr) n = 0;
          else if (load) n = g2b(64'(lg) & m, wv[i]);
          else if (inc && !dec) begin
            if (c == m) begin
              if (wp[i]) begin n = 0; w = 1'b1; end
            end else n = c + 1;
          end else if (dec && !inc) begin
            if (c == 0) begin
              if (wp[i]) begin n = m; w = 1'b1; end
            end else n = c - 1;
          end
          if (i == 0 && !clr && !load && (inc ^ dec) && n != c) single = 1'b1;
        end
        mc[i] = n;
        mw[i] = w;
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // ---------------- per-cycle compare ----------------
  logic [63:0] prev_grey = '0;
  logic [63:0] cm, cc, cs;

  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      cm = mx(wv[i]);
      cc = mc[i];
      cs = (cc == cm) ? (wp[i] ? 64'd0 : cc) : cc + 1;
      chk($sformatf("bin[%0d]", i),       o_bin[i],       cc);
      chk($sformatf("grey[%0d]", i),      o_grey[i],      gr(cc));
      chk($sformatf("grey_next[%0d]", i), o_gn[i],        gr(cs));
      chk($sformatf("at_max[%0d]", i),    64'(o_max[i]),  64'(cc == cm));
      chk($sformatf("at_min[%0d]", i),    64'(o_min[i]),  64'(cc == 0));
      chk($sformatf("wrapped[%0d]", i),   64'(o_wr[i]),   64'(mw[i]));
    end
    if (single) chk("one_bit_step", 64'($countones(o_grey[0] ^ prev_grey)), 64'd1);
    prev_grey = o_grey[0];
  end

  // ---------------- directed stimulus ----------------
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  initial begin
    repeat (3) step();
    chk("rst_bin", 64'(a_bin), 64'd0);
    chk("rst_grey_next", 64'(a_gn), 64'd1);
    chk("rst_at_min", 64'(a_min), 64'd1);
    rst = 1'b1;
    step();
    step();

    // 64 increments: full wrap at WIDTH=6, sixteen cycles at WIDTH=2
    inc = 1'b1;
    for (int k = 1; k <= 64; k++) begin
      step();
      if (k == 1)  chk("seq_k1",  64'(a_grey), 64'h01);
      if (k == 2)  chk("seq_k2",  64'(a_grey), 64'h03);
      if (k == 3)  chk("seq_k3",  64'(a_grey), 64'h02);
      if (k == 63) chk("seq_k63", 64'(a_grey), 64'h20);
      if (k == 63) chk("seq_k63_wr", 64'(a_wr), 64'd0);
      if (k == 64) chk("seq_k64", 64'(a_grey), 64'h00);
      if (k == 64) chk("seq_k64_wr", 64'(a_wr), 64'd1);
      if (k == 1)  chk("w2_k1", 64'(c_grey), 64'h1);
      if (k == 2)  chk("w2_k2", 64'(c_grey), 64'h3);
      if (k == 3)  chk("w2_k3", 64'(c_grey), 64'h2);
      if (k == 4)  chk("w2_k4", 64'(c_grey), 64'h0);
    end
    inc = 1'b0;
    step();
    chk("wr_drop", 64'(a_wr), 64'd0);

    // load Gray 0x25 (binary 57), inc, dec
    lg = 32'h25; load = 1'b1; step(); load = 1'b0;
    chk("load_bin", 64'(a_bin), 64'd57);
    inc = 1'b1; step(); inc = 1'b0;
    chk("inc_bin", 64'(a_bin), 64'd58);
    chk("inc_grey", 64'(a_grey), 64'h27);
    dec = 1'b1; step(); dec = 1'b0;
    chk("dec_grey", 64'(a_grey), 64'h25);

    // saturating build at max then at zero
    lg = 32'h20; load = 1'b1; step(); load = 1'b0;
    inc = 1'b1; repeat (3) step(); inc = 1'b0;
    chk("sat_grey", 64'(b_grey), 64'h20);
    chk("sat_max", 64'(b_max), 64'd1);
    chk("sat_wr", 64'(b_wr), 64'd0);
    chk("sat_gn", 64'(b_gn), 64'h20);
    dec = 1'b1; step(); dec = 1'b0;
    chk("sat_dec_bin", 64'(b_bin), 64'd62);
    chk("sat_dec_grey", 64'(b_grey), 64'h21);
    clr = 1'b1; step(); clr = 1'b0;
    dec = 1'b1; step(); step(); dec = 1'b0;
    chk("sat0_bin", 64'(b_bin), 64'd0);
    chk("sat0_min", 64'(b_min), 64'd1);
    chk("sat0_wr", 64'(b_wr), 64'd0);

    // priority with count 10 (Gray 0x0F)
    lg = 32'h0F; load = 1'b1; step(); load = 1'b0;
    inc = 1'b1; dec = 1'b1; step(); dec = 1'b0;
    chk("pri_incdec", 64'(a_bin), 64'd10);
    clr = 1'b1; load = 1'b1; lg = 32'h25; step(); clr = 1'b0;
    chk("pri_clr", 64'(a_bin), 64'd0);
    step(); load = 1'b0; inc = 1'b0;
    chk("pri_load", 64'(a_bin), 64'd57);

    // asynchronous reset at count 40 with inc held
    lg = 32'h3C; load = 1'b1; step(); load = 1'b0;
    chk("pre_rst_bin", 64'(a_bin), 64'd40);
    inc = 1'b1; rst = 1'b0; #1;
    chk("arst_bin", 64'(a_bin), 64'd0);
    chk("arst_grey", 64'(a_grey), 64'd0);
    chk("arst_gn", 64'(a_gn), 64'd1);
    step(); step(); rst = 1'b1;
    step(); chk("rel_e1", 64'(a_bin), 64'd0);
    step(); chk("rel_e2", 64'(a_bin), 64'd0);
    step(); chk("rel_e3", 64'(a_bin), 64'd1);
    inc = 1'b0;

    // WIDTH=32 wrap from all-ones
    lg = 32'h8000_0000; load = 1'b1; step(); load = 1'b0;
    chk("w32_load", 64'(d_bin), 64'hFFFF_FFFF);
    inc = 1'b1; step(); inc = 1'b0;
    chk("w32_grey", 64'(d_grey), 64'd0);
    chk("w32_wr", 64'(d_wr), 64'd1);
    step();
    chk("w32_wr_drop", 64'(d_wr), 64'd0);
    repeat (2) step();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
